score_keeper: RTL

- Upstream game-state stage for the score display generator.
- Turns two raw player pushbuttons into debounced point events and keeps two 2-digit BCD scores.
- Detects a win and publishes frame-stable copies of the scores.
- Display copies update only on the VGA frame-start pulse, so the pattern generator never shows a half-updated score mid-frame.

---
 rtl/score_keeper_pkg.sv | 34 +++
 rtl/score_keeper_debouncer.sv | 68 ++++++
 rtl/score_keeper.sv | 131 +++++++++++++
 3 files changed

// File: rtl/score_keeper_pkg.sv
// score_pkg: shared types, winner encodings and the BCD increment helper
// used by the score_keeper game-state block.
//   bcd2_t       : two-digit packed BCD ([7:4] tens, [3:0] units)
//   game_state_t : PLAY / OVER
//   WIN_*        : winner field encodings
//   bcd2_inc()   : BCD +1, saturating at 8'h99
package score_pkg;

  typedef logic [7:0] bcd2_t;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } game_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  // Units roll 9 -> 0 with a carry into tens; 99 holds at 99.
  function automatic bcd2_t bcd2_inc(input bcd2_t v);
    bcd2_t r;
    if (v == 8'h99) begin
      r = 8'h99;
    end else if (v[3:0] >= 4'd9) begin
      r = {v[7:4] + 4'd1, 4'h0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/score_keeper_debouncer.sv
// debouncer: 2-FF synchronizer, consecutive-cycle debounce counter and
// rising-edge detector for one raw pushbutton.
//   clk        : clock
//   rst_n      : synchronous reset, active-low
//   raw_in     : raw asynchronous button level
//   stable     : debounced level
//   rise_pulse : one-cycle pulse in the cycle stable first reads 1
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic stable,
  output logic rise_pulse
);
  import score_pkg::*;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;

  always_comb begin
    sync1_d  = raw_in;
    sync2_d  = sync1_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    // The count only advances while the synchronized level disagrees with
    // the accepted level; any agreement (a bounce back) restarts it.
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = '0;
        rise_d   = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
    end
  end

  assign stable     = stable_q;
  assign rise_pulse = rise_q;

endmodule

// File: rtl/score_keeper.sv
// score_keeper: turns two raw player buttons into debounced point events,
// keeps two 2-digit BCD scores, detects the win and publishes copies of the
// game state that only change on the VGA frame-start pulse.
//   clk         : pixel clock
//   rst_n       : synchronous reset, active-low
//   btn_p1/p2   : raw asynchronous pushbuttons, active-high
//   clear       : game restart request, active-high
//   frame_start : one-cycle pulse at start of vertical blanking
//   disp_p1/p2  : frame-latched BCD scores
//   game_over   : frame-latched OVER flag
//   winner      : frame-latched winner (00 none, 01 P1, 10 P2, 11 tie)
module score_keeper #(
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter logic [7:0] WIN_SCORE       = 8'h11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_p1,
  input  logic       btn_p2,
  input  logic       clear,
  input  logic       frame_start,
  output logic [7:0] disp_p1,
  output logic [7:0] disp_p2,
  output logic       game_over,
  output logic [1:0] winner
);
  import score_pkg::*;

  logic stable_p1, stable_p2;
  logic pt_p1, pt_p2;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_p1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_in     (btn_p1),
    .stable     (stable_p1),
    .rise_pulse (pt_p1)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_p2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_in     (btn_p2),
    .stable     (stable_p2),
    .rise_pulse (pt_p2)
  );

  game_state_t state_q, state_d;
  bcd2_t       score_p1_q, score_p1_d;
  bcd2_t       score_p2_q, score_p2_d;
  logic [1:0]  win_q, win_d;
  bcd2_t       disp_p1_q, disp_p1_d;
  bcd2_t       disp_p2_q, disp_p2_d;
  logic        over_q, over_d;
  logic [1:0]  winner_q, winner_d;
  logic        hit_p1, hit_p2;

  // Game FSM and score update.
  always_comb begin
    state_d    = state_q;
    score_p1_d = score_p1_q;
    score_p2_d = score_p2_q;
    win_d      = win_q;
    hit_p1     = 1'b0;
    hit_p2     = 1'b0;
    if (clear) begin
      state_d    = PLAY;
      score_p1_d = 8'h00;
      score_p2_d = 8'h00;
      win_d      = WIN_NONE;
    end else if ((state_q == PLAY) && (pt_p1 || pt_p2)) begin
      if (pt_p1) begin
        score_p1_d = bcd2_inc(score_p1_q);
      end
      if (pt_p2) begin
        score_p2_d = bcd2_inc(score_p2_q);
      end
      // Win is judged on the post-increment scores so a simultaneous
      // finishing point for both players yields a tie.
      hit_p1 = (score_p1_d == WIN_SCORE);
      hit_p2 = (score_p2_d == WIN_SCORE);
      if (hit_p1 || hit_p2) begin
        state_d = OVER;
        win_d   = {hit_p2, hit_p1};
      end
    end
  end

  // Display latch loads the just-computed next state so a point or clear
  // coinciding with frame_start shows up in the same frame.
  always_comb begin
    disp_p1_d = disp_p1_q;
    disp_p2_d = disp_p2_q;
    over_d    = over_q;
    winner_d  = winner_q;
    if (frame_start) begin
      disp_p1_d = score_p1_d;
      disp_p2_d = score_p2_d;
      over_d    = (state_d == OVER);
      winner_d  = win_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= PLAY;
      score_p1_q <= 8'h00;
      score_p2_q <= 8'h00;
      win_q      <= WIN_NONE;
      disp_p1_q  <= 8'h00;
      disp_p2_q  <= 8'h00;
      over_q     <= 1'b0;
      winner_q   <= WIN_NONE;
    end else begin
      state_q    <= state_d;
      score_p1_q <= score_p1_d;
      score_p2_q <= score_p2_d;
      win_q      <= win_d;
      disp_p1_q  <= disp_p1_d;
      disp_p2_q  <= disp_p2_d;
      over_q     <= over_d;
      winner_q   <= winner_d;
    end
  end

  assign disp_p1   = disp_p1_q;
  assign disp_p2   = disp_p2_q;
  assign game_over = over_q;
  assign winner    = winner_q;

endmodule
